ram32_arb: RTL and testbench

Two-port arbiter and sequencer for one 32×32-bit RAM32 macro. It shares the single RAM port between requester A (core load/store path) and requester B (debug/loader path). It uses round-robin arbitration with an optional lock for atomic multi-access sequences. All RAM-side signals are registered. Read data returns to the issuing requester with a fixed latency and a per-port valid strobe.

---
 rtl/ram32_arb.sv | 162 ++++++++++++++++
 tb/tb_ram32_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram32_arb.sv
// ram32_arb: shares one RAM32 macro port between requester A (core) and
// requester B (debug/loader). Round-robin or fixed-priority arbitration,
// an optional lock for atomic sequences, registered RAM-side signals and
// a two-stage tag pipe that routes read data back to the issuing port.
module ram32_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  // requester A
  input  logic        i_a_req,
  input  logic [3:0]  i_a_we,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_a_lock,
  output logic        o_a_gnt,
  output logic        o_a_rvalid,
  output logic [31:0] o_a_rdata,
  // requester B
  input  logic        i_b_req,
  input  logic [3:0]  i_b_we,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_wdata,
  input  logic        i_b_lock,
  output logic        o_b_gnt,
  output logic        o_b_rvalid,
  output logic [31:0] o_b_rdata,
  // RAM32 macro port
  output logic        o_ram_en,
  output logic [3:0]  o_ram_we,
  output logic [4:0]  o_ram_a,
  output logic [31:0] o_ram_di,
  input  logic [31:0] i_ram_do
);

  // Port index 0 is A, 1 is B throughout.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]  w_req;
  logic [1:0]  w_lock;
  logic [1:0]  w_gnt;
  logic [3:0]  w_we    [2];
  logic [4:0]  w_addr  [2];
  logic [31:0] w_wdata [2];
  logic        w_acc;
  logic        w_sel;
  logic        w_sel_rd;

  logic        r_last;
  logic        r_locked;
  logic        r_owner;

  logic        r_ram_en;
  logic [3:0]  r_ram_we;
  logic [4:0]  r_ram_a;
  logic [31:0] r_ram_di;

  logic        r_tag1_rd;
  logic        r_tag1_port;
  logic        r_tag2_rd;
  logic        r_tag2_port;

  logic [1:0]  w_rvalid;
  logic [31:0] w_rdata [2];

  assign w_req      = {i_b_req, i_a_req};
  assign w_lock     = {i_b_lock, i_a_lock};
  assign w_we[0]    = i_a_we;
  assign w_we[1]    = i_b_we;
  assign w_addr[0]  = i_a_addr;
  assign w_addr[1]  = i_b_addr;
  assign w_wdata[0] = i_a_wdata;
  assign w_wdata[1] = i_b_wdata;

  // Combinational grant: lock owner first, then contention resolution.
  always_comb begin
    w_gnt = 2'b00;
    if (!i_rst_n) begin
      w_gnt = 2'b00;
    end else if (r_locked) begin
      w_gnt[r_owner] = w_req[r_owner];
    end else if (&w_req) begin
      // r_last == B means A has the turn; fixed priority always picks A.
      w_gnt = (FIXED_PRIO || (r_last == PORT_B)) ? 2'b01 : 2'b10;
    end else begin
      w_gnt = w_req;
    end
  end

  assign o_a_gnt  = w_gnt[0];
  assign o_b_gnt  = w_gnt[1];
  assign w_acc    = |w_gnt;
  assign w_sel    = w_gnt[1];
  assign w_sel_rd = (w_we[w_sel] == 4'b0000);

  // Arbitration state: last winner and lock ownership, updated on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last   <= PORT_B;
      r_locked <= 1'b0;
      r_owner  <= PORT_A;
    end else if (w_acc) begin
      r_last   <= w_sel;
      // Only the owner can be accepted while locked, so the accepted
      // transfer's lock bit alone decides whether the lock persists.
      r_locked <= w_lock[w_sel];
      if (w_lock[w_sel]) begin
        r_owner <= w_sel;
      end
    end
  end

  // Registered RAM command; address and data hold when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_en <= 1'b0;
      r_ram_we <= 4'b0000;
      r_ram_a  <= 5'd0;
      r_ram_di <= 32'd0;
    end else begin
      r_ram_en <= w_acc;
      r_ram_we <= w_acc ? w_we[w_sel] : 4'b0000;
      if (w_acc) begin
        r_ram_a  <= w_addr[w_sel];
        r_ram_di <= w_wdata[w_sel];
      end
    end
  end

  // Tag pipe: stage 2 lines up with the cycle the RAM presents read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag1_rd   <= 1'b0;
      r_tag1_port <= PORT_A;
      r_tag2_rd   <= 1'b0;
      r_tag2_port <= PORT_A;
    end else begin
      r_tag1_rd   <= w_acc && w_sel_rd;
      r_tag1_port <= w_sel;
      r_tag2_rd   <= r_tag1_rd;
      r_tag2_port <= r_tag1_port;
    end
  end

  // Per-port read return; data is forced to zero when not valid.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign w_rvalid[gi] = r_tag2_rd && (r_tag2_port == 1'(gi));
    assign w_rdata[gi]  = w_rvalid[gi] ? i_ram_do : 32'd0;
  end

  assign o_a_rvalid = w_rvalid[0];
  assign o_b_rvalid = w_rvalid[1];
  assign o_a_rdata  = w_rdata[0];
  assign o_b_rdata  = w_rdata[1];

  assign o_ram_en = r_ram_en;
  assign o_ram_we = r_ram_we;
  assign o_ram_a  = r_ram_a;
  assign o_ram_di = r_ram_di;

endmodule

// File: tb/tb_ram32_arb.sv
// Bench for ram32_arb: two instances (round-robin and fixed priority) share
// the same stimulus, each with its own RAM32 behavioural model. A reference
// model predicts grants, RAM commands and read returns; read returns are
// queued by due cycle and checked by an independent monitor.
module tb_ram32_arb;

  typedef struct {
    bit          req;
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] wd;
    bit          lock;
  } req_t;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_lock = 1'b0, b_req = 1'b0, b_lock = 1'b0;
  logic [3:0]  a_we = 4'h0, b_we = 4'h0;
  logic [4:0]  a_addr = 5'd0, b_addr = 5'd0;
  logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;

  logic [1:0]  a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en;
  logic [31:0] a_rdata [2];
  logic [31:0] b_rdata [2];
  logic [31:0] ram_di  [2];
  logic [31:0] ram_do  [2];
  logic [3:0]  ram_we  [2];
  logic [4:0]  ram_a   [2];

  ram32_arb #(.FIXED_PRIO(1'b0)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_lock(a_lock),
    .o_a_gnt(a_gnt[0]), .o_a_rvalid(a_rvalid[0]), .o_a_rdata(a_rdata[0]),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_lock(b_lock),
    .o_b_gnt(b_gnt[0]), .o_b_rvalid(b_rvalid[0]), .o_b_rdata(b_rdata[0]),
    .o_ram_en(ram_en[0]), .o_ram_we(ram_we[0]), .o_ram_a(ram_a[0]), .o_ram_di(ram_di[0]),
    .i_ram_do(ram_do[0])
  );

  ram32_arb #(.FIXED_PRIO(1'b1)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_lock(a_lock),
    .o_a_gnt(a_gnt[1]), .o_a_rvalid(a_rvalid[1]), .o_a_rdata(a_rdata[1]),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_lock(b_lock),
    .o_b_gnt(b_gnt[1]), .o_b_rvalid(b_rvalid[1]), .o_b_rdata(b_rdata[1]),
    .o_ram_en(ram_en[1]), .o_ram_we(ram_we[1]), .o_ram_a(ram_a[1]), .o_ram_di(ram_di[1]),
    .i_ram_do(ram_do[1])
  );

  // RAM32 behavioural model: synchronous, byte writes, read data discarded on write.
  logic [31:0] ram_mem [2][32];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en[d]) begin
        if (ram_we[d] == 4'h0) begin
          ram_do[d] <= ram_mem[d][ram_a[d]];
        end else begin
          for (int k = 0; k < 4; k++)
            if (ram_we[d][k]) ram_mem[d][ram_a[d]][k*8 +: 8] <= ram_di[d][k*8 +: 8];
          ram_do[d] <= $urandom;
        end
      end
    end
  end

  // Counts rising edges; used to time read returns.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  bit          m_last   [2];
  bit          m_locked [2];
  bit          m_owner  [2];
  logic [31:0] m_mem    [2][32];
  bit          e_en     [2];
  logic [3:0]  e_we     [2];
  logic [4:0]  e_a      [2];
  logic [31:0] e_di     [2];
  bit          in_rst = 1'b1;
  exp_t        q0 [$];
  exp_t        q1 [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_last[d]   = 1'b1;
      m_locked[d] = 1'b0;
      m_owner[d]  = 1'b0;
      e_en[d]     = 1'b0;
      e_we[d]     = 4'h0;
      e_a[d]      = 5'd0;
      e_di[d]     = 32'h0;
    end
    q0.delete();
    q1.delete();
  endfunction

  // Expected grant {b,a}: the lock owner rules; otherwise the lone requester
  // wins, and under contention A wins if fixed priority or B went last.
  function automatic logic [1:0] model_gnt(input int d, input bit ar, input bit br);
    if (in_rst) return 2'b00;
    if (m_locked[d]) return m_owner[d] ? {br, 1'b0} : {1'b0, ar};
    if (ar && br) return (d == 1 || m_last[d]) ? 2'b01 : 2'b10;
    return {br, ar};
  endfunction

  function automatic req_t mk(input bit req, input logic [3:0] we, input logic [4:0] addr,
                              input logic [31:0] wd, input bit lock);
    req_t r;
    r.req = req; r.we = we; r.addr = addr; r.wd = wd; r.lock = lock;
    return r;
  endfunction

  // One clock cycle of stimulus; starts and ends just after a falling edge.
  task automatic drive(input bit rst_v, input req_t ra, input req_t rb);
    logic [1:0] g [2];
    req_t       r;
    int         base;
    string      line;
    #2;
    rst_n   = rst_v;
    a_req   = ra.req; a_we = ra.we; a_addr = ra.addr; a_wdata = ra.wd; a_lock = ra.lock;
    b_req   = rb.req; b_we = rb.we; b_addr = rb.addr; b_wdata = rb.wd; b_lock = rb.lock;
    if (!rst_v) begin
      in_rst = 1'b1;
      model_reset();
    end else begin
      in_rst = 1'b0;
    end
    #1;
    base = cyc;
    for (int d = 0; d < 2; d++) begin
      g[d] = model_gnt(d, ra.req, rb.req);
      chk(d == 0 ? "gnt_rr" : "gnt_fp", {126'd0, b_gnt[d], a_gnt[d]}, {126'd0, g[d]});
      chk(d == 0 ? "ram_rr" : "ram_fp", {86'd0, ram_en[d], ram_we[d], ram_a[d], ram_di[d]},
          {86'd0, e_en[d], e_we[d], e_a[d], e_di[d]});
    end
    @(posedge clk);
    line = $sformatf("cyc %0d rst_n=%0b", base + 1, rst_v);
    for (int d = 0; d < 2; d++) begin
      if (in_rst) continue;
      e_en[d] = |g[d];
      if (|g[d]) begin
        r = g[d][1] ? rb : ra;
        e_we[d] = r.we; e_a[d] = r.addr; e_di[d] = r.wd;
        if (r.we == 4'h0) begin
          exp_t e;
          e.port = g[d][1]; e.data = m_mem[d][r.addr]; e.due = base + 2;
          if (d == 0) q0.push_back(e); else q1.push_back(e);
        end else begin
          for (int k = 0; k < 4; k++)
            if (r.we[k]) m_mem[d][r.addr][k*8 +: 8] = r.wd[k*8 +: 8];
        end
        m_last[d]   = g[d][1];
        m_locked[d] = r.lock;
        if (r.lock) m_owner[d] = g[d][1];
        line = {line, $sformatf(" | %s acc %s we=%h addr=%0d wd=%h lock=%0b",
                d == 0 ? "rr" : "fp", g[d][1] ? "B" : "A", r.we, r.addr, r.wd, r.lock)};
      end else begin
        e_we[d] = 4'h0;
        line = {line, $sformatf(" | %s idle", d == 0 ? "rr" : "fp")};
      end
    end
    $display("%s", line);
    @(negedge clk);
  endtask

  // Monitor: every cycle, each port's rvalid/rdata must match the queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit   hit;
      hit = 1'b0;
      e.port = 1'b0; e.data = 32'h0; e.due = 0;
      if (d == 0) begin
        if (q0.size() != 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
      end else begin
        if (q1.size() != 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
      end
      chk(d == 0 ? "rd_rr" : "rd_fp",
          {62'd0, a_rvalid[d], b_rvalid[d], a_rdata[d], b_rdata[d]},
          {62'd0, hit && !e.port, hit && e.port,
           (hit && !e.port) ? e.data : 32'h0, (hit && e.port) ? e.data : 32'h0});
    end
  end

  initial begin
    req_t idle, ra, rb;
    idle = mk(0, 4'h0, 5'd0, 32'h0, 0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        ram_mem[d][i] = 32'h0;
        m_mem[d][i]   = 32'h0;
      end
    model_reset();

    // Reset: grants forced low even with requests, RAM outputs zero.
    @(negedge clk);
    drive(0, idle, idle);
    drive(0, mk(1, 4'hF, 5'd3, 32'h12345678, 1), mk(1, 4'h0, 5'd2, 32'h0, 1));
    drive(1, idle, idle);

    // Basic write then read on port A.
    drive(1, mk(1, 4'hF, 5'd3, 32'hDEADBEEF, 0), idle);
    drive(1, mk(1, 4'h0, 5'd3, 32'h0, 0), idle);
    repeat (3) drive(1, idle, idle);

    // Byte enables.
    drive(1, mk(1, 4'hF, 5'd7, 32'h11223344, 0), idle);
    drive(1, mk(1, 4'b0010, 5'd7, 32'hAAAAAAAA, 0), idle);
    drive(1, mk(1, 4'h0, 5'd7, 32'h0, 0), idle);
    repeat (2) drive(1, idle, idle);

    // Preload and continuous contention.
    drive(1, mk(1, 4'hF, 5'd1, 32'h1, 0), idle);
    drive(1, mk(1, 4'hF, 5'd2, 32'h2, 0), idle);
    repeat (8) drive(1, mk(1, 4'h0, 5'd1, 32'h0, 0), mk(1, 4'h0, 5'd2, 32'h0, 0));
    repeat (3) drive(1, idle, idle);

    // Lock sequence 1,1,0 with B requesting throughout.
    drive(1, idle, mk(1, 4'h0, 5'd2, 32'h0, 0));
    drive(1, mk(1, 4'hF, 5'd4, 32'h44, 1), mk(1, 4'h0, 5'd2, 32'h0, 0));
    drive(1, mk(1, 4'h0, 5'd4, 32'h0, 1), mk(1, 4'h0, 5'd2, 32'h0, 0));
    drive(1, mk(1, 4'hF, 5'd5, 32'h55, 0), mk(1, 4'h0, 5'd2, 32'h0, 0));
    drive(1, idle, mk(1, 4'h0, 5'd2, 32'h0, 0));

    // Owner idles while locked: B stalls until A releases.
    drive(1, mk(1, 4'h0, 5'd5, 32'h0, 1), idle);
    repeat (2) drive(1, idle, mk(1, 4'h0, 5'd4, 32'h0, 1));
    drive(1, mk(1, 4'h0, 5'd4, 32'h0, 0), mk(1, 4'h0, 5'd4, 32'h0, 1));
    drive(1, idle, mk(1, 4'h0, 5'd4, 32'h0, 0));
    repeat (2) drive(1, idle, idle);

    // Back-to-back write then read on B, address 31.
    drive(1, idle, mk(1, 4'hF, 5'd31, 32'hCAFEF00D, 0));
    drive(1, idle, mk(1, 4'h0, 5'd31, 32'h0, 0));
    repeat (3) drive(1, idle, idle);

    // Reset one cycle after a read accept: the read never returns.
    drive(1, mk(1, 4'h0, 5'd3, 32'h0, 0), idle);
    drive(0, idle, idle);
    drive(0, idle, idle);
    repeat (4) drive(1, idle, idle);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      ra = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
              5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) == 0);
      rb = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)),
              5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3) == 0);
      drive($urandom_range(0, 99) != 0, ra, rb);
    end
    repeat (4) drive(1, idle, idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
